// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: shift-add multiplier and restoring divider
// that stalls the single-cycle pipeline until the result commits in DONE.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clock_proc,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  logic [XLEN-1:0]     mag_a_q, mag_a_d;
  logic [XLEN-1:0]     mag_b_q, mag_b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic                resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]     resp_result_q, resp_result_d;

  // Request decode and special cases
  logic            req_is_div, a_signed, b_signed, sign_a_in, sign_b_in;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] mag_a_in, mag_b_in, special_result;

  always_comb begin
    req_is_div = req_funct3[2];
    a_signed   = (req_funct3 == 3'd1) || (req_funct3 == 3'd2) ||
                 (req_funct3 == 3'd4) || (req_funct3 == 3'd6);
    b_signed   = (req_funct3 == 3'd1) || (req_funct3 == 3'd4) || (req_funct3 == 3'd6);
    sign_a_in  = a_signed & req_rs1[XLEN-1];
    sign_b_in  = b_signed & req_rs2[XLEN-1];
    mag_a_in   = sign_a_in ? -req_rs1 : req_rs1;
    mag_b_in   = sign_b_in ? -req_rs2 : req_rs2;
    div_zero   = (req_rs2 == '0);
    div_ovf    = ~req_funct3[0] && (req_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (req_rs2 == '1);
    special    = req_is_div && (div_zero || div_ovf);
    if (req_funct3[1])
      special_result = div_zero ? req_rs1 : '0;
    else
      special_result = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One iteration of each algorithm
  logic [XLEN:0] mul_sum, div_shift, div_diff;
  logic          div_ok;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    div_shift = {rem_q, acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mag_b_q};
    div_ok    = ~div_diff[XLEN];
  end

  // Sign fix-up and result select
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quotient, remainder, fix_result;

  always_comb begin
    product   = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quotient  = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    remainder = sign_a_q ? -rem_q : rem_q;
    case (funct3_q)
      3'd0:       fix_result = product[XLEN-1:0];
      3'd4, 3'd5: fix_result = quotient;
      3'd6, 3'd7: fix_result = remainder;
      default:    fix_result = product[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    funct3_d      = funct3_q;
    sign_a_d      = sign_a_q;
    sign_b_d      = sign_b_q;
    mag_a_d       = mag_a_q;
    mag_b_d       = mag_b_q;
    acc_d         = acc_q;
    rem_d         = rem_q;
    resp_valid_d  = 1'b0;
    resp_result_d = resp_result_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          if (special) begin
            state_d       = DONE;
            resp_valid_d  = 1'b1;
            resp_result_d = special_result;
          end else begin
            state_d  = CALC;
            cnt_d    = '0;
            funct3_d = req_funct3;
            sign_a_d = sign_a_in;
            sign_b_d = sign_b_in;
            mag_a_d  = mag_a_in;
            mag_b_d  = mag_b_in;
            rem_d    = '0;
            // Low half holds the multiplier or the dividend to be shifted out
            acc_d    = {{XLEN{1'b0}}, (req_is_div ? mag_a_in : mag_b_in)};
          end
        end
        CALC: begin
          cnt_d = cnt_q + 1'b1;
          if (funct3_q[2]) begin
            rem_d = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ok};
          end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          end
          if (cnt_q == CW'(XLEN-1)) state_d = FIX;
        end
        FIX: begin
          state_d       = DONE;
          resp_valid_d  = 1'b1;
          resp_result_d = fix_result;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_proc) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      funct3_q      <= '0;
      sign_a_q      <= 1'b0;
      sign_b_q      <= 1'b0;
      mag_a_q       <= '0;
      mag_b_q       <= '0;
      acc_q         <= '0;
      rem_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      funct3_q      <= funct3_d;
      sign_a_q      <= sign_a_d;
      sign_b_q      <= sign_b_d;
      mag_a_q       <= mag_a_d;
      mag_b_q       <= mag_b_d;
      acc_q         <= acc_d;
      rem_q         <= rem_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
    end
  end

  assign stall       = ((state_q == IDLE) && req_valid) || (state_q == CALC) || (state_q == FIX);
  assign busy        = (state_q != IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: per-cycle latency/result model plus
// hand-computed literal results for each directed vector.
module tb_muldiv_sequencer;

  logic        clock_proc = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic        flush = 1'b0;
  logic        stall, busy, resp_valid;
  logic [31:0] resp_result;

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;
  bit done_run = 1'b0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clock_proc (clock_proc),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_funct3 (req_funct3),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .flush      (flush),
    .stall      (stall),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_result(resp_result)
  );

  always #5 clock_proc = ~clock_proc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Architectural RV32M result straight from the ISA definition
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, zb;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    zb = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * zb); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Latency model: cycles left before the response cycle, and the response itself
  int          m_left = 0;
  bit          m_resp_now = 1'b0;
  logic [31:0] m_result = '0;
  logic [31:0] m_pending = '0;

  always @(negedge clock_proc) begin
    bit in_flight;
    in_flight = (m_left > 0);
    if (armed) begin
      check("cyc stall", 32'(stall), 32'(m_resp_now ? 1'b0 : (in_flight ? 1'b1 : req_valid)));
      check("cyc busy", 32'(busy), 32'(in_flight || m_resp_now));
      check("cyc resp_valid", 32'(resp_valid), 32'(m_resp_now));
      check("cyc resp_result", resp_result, m_result);
    end
    if (!rst) begin
      m_left = 0; m_resp_now = 1'b0; m_result = '0;
    end else if (flush) begin
      m_left = 0; m_resp_now = 1'b0;
    end else if (m_resp_now) begin
      m_resp_now = 1'b0;
    end else if (in_flight) begin
      m_left--;
      if (m_left == 0) begin m_resp_now = 1'b1; m_result = m_pending; end
    end else if (req_valid) begin
      m_pending = ref_op(req_funct3, req_rs1, req_rs2);
      if (is_special(req_funct3, req_rs1, req_rs2)) begin
        m_resp_now = 1'b1; m_result = m_pending;
      end else begin
        m_left = 33;
      end
    end
  end

  // Present one instruction, hold it until it commits, and check the literal result
  task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int k, stalls;
    bit got;
    @(posedge clock_proc); #1;
    req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b;
    k = 0; stalls = 0; got = 1'b0;
    while (!got && k < 100) begin
      @(negedge clock_proc);
      if (stall) stalls++;
      if (resp_valid) got = 1'b1;
      else k++;
    end
    if (!got) begin
      check({name, " timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, " result"}, resp_result, exp);
      check({name, " latency"}, 32'(k), 32'(exp_lat));
      check({name, " stall cycles"}, 32'(stalls), 32'(exp_lat));
    end
    $display("op %-12s f3=%0d a=%h b=%h -> %h latency=%0d stalls=%0d", name, f3, a, b, resp_result, k, stalls);
  endtask

  task automatic go_idle(input int n);
    @(posedge clock_proc); #1;
    req_valid = 1'b0;
    repeat (n) @(posedge clock_proc);
  endtask

  initial begin
    int spurious;
    rst = 1'b0;
    @(posedge clock_proc); #1;
    armed = 1'b1;
    @(negedge clock_proc);
    check("reset resp_result", resp_result, 32'h0);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(posedge clock_proc); #1;
    rst = 1'b1;

    issue("MUL",       3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    issue("MULHU",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    issue("MULHSU",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    issue("MULH",      3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
    issue("DIVU_by0",  3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    issue("REM_by0",   3'd6, 32'd5,          32'd0,         32'd5,         1);
    issue("DIV_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    issue("REM_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1);
    issue("DIV",       3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
    issue("REM",       3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
    issue("DIVU",      3'd5, 32'd100,        32'd7,         32'd14,        34);
    issue("REMU",      3'd7, 32'd100,        32'd7,         32'd2,         34);
    go_idle(2);

    // Flush while the counter reads 10
    @(posedge clock_proc); #1;
    req_valid = 1'b1; req_funct3 = 3'd0; req_rs1 = 32'd3; req_rs2 = 32'd5;
    repeat (11) @(posedge clock_proc);
    #1; flush = 1'b1; req_valid = 1'b0;
    @(posedge clock_proc); #1; flush = 1'b0;
    spurious = 0;
    repeat (40) begin
      @(negedge clock_proc);
      if (resp_valid) spurious++;
    end
    check("flush no resp_valid", 32'(spurious), 32'd0);
    check("flush result kept", resp_result, 32'd2);
    check("flush back to idle", 32'(busy), 32'd0);
    $display("flush during CALC: spurious=%0d result=%h", spurious, resp_result);

    issue("DIVU_9_3", 3'd5, 32'd9, 32'd3, 32'd3, 34);
    go_idle(1);

    // Flush with a request pending in IDLE must not start it
    @(posedge clock_proc); #1;
    req_valid = 1'b1; flush = 1'b1; req_funct3 = 3'd0; req_rs1 = 32'd2; req_rs2 = 32'd2;
    @(posedge clock_proc); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clock_proc);
    check("idle flush no start", 32'(busy), 32'd0);
    $display("flush in IDLE with request: busy=%0d", busy);

    // Reset for a single edge in the middle of CALC
    @(posedge clock_proc); #1;
    req_valid = 1'b1; req_funct3 = 3'd0; req_rs1 = 32'd9; req_rs2 = 32'd9;
    repeat (5) @(posedge clock_proc);
    #1; rst = 1'b0; req_valid = 1'b0;
    @(posedge clock_proc); #1; rst = 1'b1;
    @(negedge clock_proc);
    check("midreset resp_valid", 32'(resp_valid), 32'd0);
    check("midreset resp_result", resp_result, 32'h0);
    check("midreset stall", 32'(stall), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    $display("reset in CALC: busy=%0d stall=%0d result=%h", busy, stall, resp_result);

    issue("MUL_b2b",  3'd0, 32'd7,   32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    issue("DIVU_b2b", 3'd5, 32'd100, 32'd7,         32'd14,        34);
    go_idle(3);

    done_run = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    if (!done_run) begin
      n_bad++;
      $display("FAIL watchdog: run did not complete, got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

endmodule
